// File: rtl/conway_board_reader_if.sv
// Row-stream bus between the board reader and a display or UART back-end.
// The master drives one board row per beat; the slave applies backpressure with out_ready.
interface conway_board_reader_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int ROW_W = $clog2(ROWS);

  logic [COLS-1:0]  out_data;
  logic [ROW_W-1:0] out_row;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data, out_row, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/conway_board_reader.sv
// Snapshots the Game of Life cell array on start and streams it row by row.
// It also reports the live-cell population of the captured generation.
module conway_board_reader #(
  parameter  int ROWS  = 8,
  parameter  int COLS  = 8,
  localparam int ROW_W = $clog2(ROWS),
  localparam int POP_W = $clog2(ROWS*COLS+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   board_q,
  conway_board_reader_if.master  bus,
  output logic                   busy,
  output logic [POP_W-1:0]       population,
  output logic                   pop_valid,
  output logic                   overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_next;
  logic [ROWS*COLS-1:0] snapshot;
  logic [ROW_W-1:0]     row;
  logic [POP_W-1:0]     acc;
  logic [COLS-1:0]      row_data;
  logic [POP_W-1:0]     row_pop;
  logic                 row_is_last;
  logic                 capture;
  logic                 fire;

  function automatic logic [POP_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  assign row_data    = snapshot[int'(row)*COLS +: COLS];
  assign row_pop     = popcount(row_data);
  assign row_is_last = (row == ROW_W'(ROWS-1));

  // Beat outputs come only from registered state, so out_valid never sees out_ready.
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = row_data;
  assign bus.out_row   = row;
  assign bus.out_last  = (state == SEND) && row_is_last;
  assign busy          = (state == SEND);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    capture    = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          fire = 1'b1;
          if (row_is_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use <= so every flop samples the pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      // NOTE: the snapshot is plain flops, not RAM, so it can and does clear on reset.
      snapshot   <= '0;
      row        <= '0;
      acc        <= '0;
      population <= '0;
      pop_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state     <= state_next;
      pop_valid <= 1'b0;
      if (capture) begin
        snapshot <= board_q;
        row      <= '0;
        acc      <= '0;
      end
      if (fire) begin
        acc <= acc + row_pop;
        if (row_is_last) begin
          population <= acc + row_pop;
          pop_valid  <= 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
      // A request arriving mid-frame is dropped, but remembered until reset.
      if (start && state == SEND) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conway_board_reader.sv
// Directed self-checking bench for conway_board_reader: an 8x8 instance for the
// main scenarios and a 3x5 instance for the small-board case.
module tb_conway_board_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] board_q;
  logic        busy;
  logic [6:0]  population;
  logic        pop_valid;
  logic        overrun;

  logic        start35;
  logic [14:0] board35;
  logic        busy35;
  logic [3:0]  population35;
  logic        pop_valid35;
  logic        overrun35;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_seen = 0;

  always #5 clk = ~clk;

  conway_board_reader_if #(.ROWS(8), .COLS(8)) bus8 ();
  conway_board_reader_if #(.ROWS(3), .COLS(5)) bus35 ();

  conway_board_reader #(.ROWS(8), .COLS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_q    (board_q),
    .bus        (bus8),
    .busy       (busy),
    .population (population),
    .pop_valid  (pop_valid),
    .overrun    (overrun)
  );

  conway_board_reader #(.ROWS(3), .COLS(5)) dut35 (
    .clk        (clk),
    .rst        (rst),
    .start      (start35),
    .board_q    (board35),
    .bus        (bus35),
    .busy       (busy35),
    .population (population35),
    .pop_valid  (pop_valid35),
    .overrun    (overrun35)
  );

  always @(negedge clk) if (pop_valid) pop_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one 8x8 frame; optional stall on one row, board inversion after
  // capture, and a stray start at one row. Returns in the pop_valid cycle.
  task automatic run_frame(input string tag, input logic [63:0] board,
                           input int stall_row, input int stall_n, input bit invert,
                           input int ov_row, input int exp_pop);
    int exp_row = 0;
    int stalls = 0;
    int valid_cycles = 0;
    bit ov_done = 1'b0;
    board_q = board;
    bus8.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (invert) board_q = ~board;
    check({tag, "_first_valid"}, 64'(bus8.out_valid), 64'd1);
    for (int cyc = 0; cyc < 40 && bus8.out_valid; cyc++) begin
      start = 1'b0;
      check({tag, "_row"}, 64'(bus8.out_row), 64'(exp_row));
      check({tag, "_data"}, 64'(bus8.out_data), 64'(board[exp_row*8 +: 8]));
      check({tag, "_last"}, 64'(bus8.out_last), 64'(exp_row == 7));
      check({tag, "_busy"}, 64'(busy), 64'd1);
      valid_cycles++;
      if (ov_row == exp_row && !ov_done) begin
        start = 1'b1;
        ov_done = 1'b1;
      end
      if (exp_row == stall_row && stalls < stall_n) begin
        bus8.out_ready = 1'b0;
        stalls++;
      end else begin
        bus8.out_ready = 1'b1;
        exp_row++;
      end
      tick();
    end
    start = 1'b0;
    bus8.out_ready = 1'b1;
    check({tag, "_valid_cycles"}, 64'(valid_cycles), 64'(8 + stall_n));
    check({tag, "_pop_valid"}, 64'(pop_valid), 64'd1);
    check({tag, "_population"}, 64'(population), 64'(exp_pop));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  // One 3x5 frame with out_ready held high; returns in the pop_valid cycle.
  task automatic frame35(input string tag, input logic [14:0] b, input int exp_pop);
    board35 = b;
    start35 = 1'b1;
    tick();
    start35 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check({tag, "_valid"}, 64'(bus35.out_valid), 64'd1);
      check({tag, "_row"}, 64'(bus35.out_row), 64'(r));
      check({tag, "_data"}, 64'(bus35.out_data), 64'(b[r*5 +: 5]));
      check({tag, "_last"}, 64'(bus35.out_last), 64'(r == 2));
      tick();
    end
    check({tag, "_valid_end"}, 64'(bus35.out_valid), 64'd0);
    check({tag, "_pop_valid"}, 64'(pop_valid35), 64'd1);
    check({tag, "_population"}, 64'(population35), 64'(exp_pop));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    rst = 1'b1;
    start = 1'b0;
    board_q = '0;
    bus8.out_ready = 1'b0;
    start35 = 1'b0;
    board35 = '0;
    bus35.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", 64'(bus8.out_valid), 64'd0);
    check("rst_data", 64'(bus8.out_data), 64'd0);
    check("rst_row", 64'(bus8.out_row), 64'd0);
    check("rst_last", 64'(bus8.out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_population", 64'(population), 64'd0);
    check("rst_pop_valid", 64'(pop_valid), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    tick();

    // Glider: rows 0x02, 0x04, 0x07, then empty.
    run_frame("glider", 64'h0000_0000_0007_0402, -1, 0, 1'b0, -1, 5);
    tick();
    check("glider_pop_pulse_width", 64'(pop_valid), 64'd0);
    check("glider_pop_hold", 64'(population), 64'd5);

    // Full board with three stalled cycles on row 2.
    run_frame("bp", 64'hFFFF_FFFF_FFFF_FFFF, 2, 3, 1'b0, -1, 64);
    check("bp_overrun_clear", 64'(overrun), 64'd0);
    tick();

    // Board inverted one cycle after capture must not affect the stream.
    run_frame("iso", 64'h0123_4567_89AB_CDEF, -1, 0, 1'b1, -1, 32);
    tick();

    // Stray start during row 4, then a legal start in the pop_valid cycle.
    run_frame("ovr", 64'hF0F0_0000_0000_00FF, -1, 0, 1'b0, 4, 16);
    check("ovr_flag", 64'(overrun), 64'd1);
    board_q = 64'h0000_0000_0000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_valid", 64'(bus8.out_valid), 64'd1);
    check("restart_row", 64'(bus8.out_row), 64'd0);
    check("restart_data", 64'(bus8.out_data), 64'h01);
    check("restart_pop_fall", 64'(pop_valid), 64'd0);
    repeat (8) tick();
    check("restart_pop_valid", 64'(pop_valid), 64'd1);
    check("restart_population", 64'(population), 64'd1);
    check("restart_overrun_sticky", 64'(overrun), 64'd1);
    tick();

    // Reset in the middle of a frame, while row 3 is on the bus.
    board_q = 64'hFFFF_FFFF_FFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("midrst_row_before", 64'(bus8.out_row), 64'd3);
    pops_before = pop_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(bus8.out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_population", 64'(population), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    check("midrst_pop_valid", 64'(pop_valid), 64'd0);
    repeat (12) tick();
    check("midrst_no_pop", 64'(pop_seen), 64'(pops_before));

    // 3x5 board: a populated frame, then an empty one started in the pop_valid cycle.
    frame35("small", 15'b11111_00000_10101, 8);
    frame35("empty", 15'b00000_00000_00000, 0);
    tick();
    check("empty_pop_fall", 64'(pop_valid35), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conway_board_reader.md
# conway_board_reader

Reads the Game of Life board out of the cell array. On a `start` pulse it snapshots the flattened `state_q` vector of all cells, streams it row by row over a valid/ready interface, and reports the live-cell population of the captured generation. It sits beside the grid and the step-enable generator, and feeds display or UART back-ends. Because it works from a snapshot, the grid may keep stepping while a frame is in flight.

## Interface
- `ROWS`, default 8: board rows; must be ≥ 2.
- `COLS`, default 8: board columns; also the width of one output beat.
- `clk` input, 1 bit: single clock; everything is on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: one-cycle request to capture and send a frame.
- `board_q` input, ROWS*COLS bits: cell states; cell (r,c) is at bit r*COLS+c.
- `out_data` output, COLS bits: one row of the snapshot; bit c is column c.
- `out_row` output, $clog2(ROWS) bits: index of the row in `out_data`.
- `out_valid` output, 1 bit: `out_data`, `out_row` and `out_last` are valid.
- `out_ready` input, 1 bit: downstream accepts the current beat.
- `out_last` output, 1 bit: the current beat is row ROWS-1.
- `busy` output, 1 bit: high while a frame is in flight.
- `population` output, $clog2(ROWS*COLS+1) bits: live-cell count of the last completed frame.
- `pop_valid` output, 1 bit: one-cycle pulse when `population` updates.
- `overrun` output, 1 bit: sticky flag, set when a `start` is dropped.

## Operation
- The FSM has two states, IDLE and SEND.
- IDLE, `start`=1:
  - Register `board_q` into the snapshot.
  - Clear the row counter and the accumulator.
  - Go to SEND.
- IDLE, `start`=0: hold all state.
- SEND drives these outputs:
  - `out_valid`=1 and `busy`=1.
  - `out_row` = row counter.
  - `out_data` = snapshot[row*COLS +: COLS].
  - `out_last` = (row == ROWS-1).
- SEND, handshake (`out_valid` && `out_ready`):
  - Add the popcount of `out_data` to the accumulator. Its width is that of `population`; it cannot overflow.
  - If `out_last`: `population` <= accumulator + popcount, pulse `pop_valid` next cycle, go to IDLE.
  - Otherwise: increment the row counter.
- SEND, `out_ready`=0: hold every output stable. Data and row must not change while valid and not accepted.
- `out_valid` never depends combinationally on `out_ready`.
- `start` while in SEND, including the final handshake cycle:
  - The request is ignored and `overrun` is set to 1.
  - `overrun` clears only on `rst`.
  - The frame in flight is not disturbed.
- `start` in the same cycle as `pop_valid` (already in IDLE) is accepted normally.
- Changes on `board_q` after capture have no effect on the frame in flight.
- Reset in any state:
  - Go to IDLE.
  - Clear the snapshot, row counter, accumulator, `population` and `overrun`.
  - Any partially sent frame is abandoned; no `pop_valid` is produced.
- Reset values of outputs: `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, `busy`=0, `population`=0, `pop_valid`=0, `overrun`=0.

## Timing
- `start` sampled at edge t: `out_valid` is high from cycle t+1 with row 0.
- With `out_ready` held high:
  - Beats are rows 0..ROWS-1 in cycles t+1..t+ROWS.
  - `out_last` is high in cycle t+ROWS.
  - IDLE and `pop_valid` fall in cycle t+ROWS+1.
- Fastest back-to-back operation: `start` in cycle t+ROWS+1 gives a new frame from t+ROWS+2.
- Each cycle `out_ready`=0 during SEND adds exactly one cycle of latency.
- `pop_valid` is exactly one cycle wide. `population` holds its value until the next frame completes.

## Test plan
- Reset: assert `rst` mid-frame at row 3 → next cycle `out_valid`=0, `busy`=0, `population`=0, `overrun`=0, and no `pop_valid`.
- Glider on 8x8, `out_ready`=1:
  - Cells (0,1), (1,2), (2,0), (2,1), (2,2) set; `start` at t.
  - Rows t+1..t+8 read 0x02, 0x04, 0x07, then 0x00 ×5.
  - `out_last` only at t+8.
  - `pop_valid` at t+9 with `population`=5.
- Backpressure: full board (all ones); drop `out_ready` for 3 cycles on row 2 → row 2 data 0xFF stays stable, total frame takes 11 cycles, `population`=64.
- Snapshot isolation: invert `board_q` one cycle after `start` → streamed rows match the pre-inversion board.
- Overrun:
  - `start` during row 4 → `overrun`=1 and the frame completes unchanged.
  - Second `start` in the `pop_valid` cycle → accepted, `out_valid` next cycle.
- Empty board, ROWS=3, COLS=5 → 3 beats of 0x00, `out_row` 0,1,2, `population`=0, `pop_valid` 4 cycles after `start`.
